// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: register map, status/ctrl bit positions and FSM encoding for the UART receiver
package uart_rx_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_PRESC  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;
  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;
  localparam int ST_BUSY = 4;
  localparam int CT_EN       = 0;
  localparam int CT_IE       = 1;
  localparam int CT_CLR_OVR  = 2;
  localparam int CT_CLR_FERR = 3;
  localparam int OVS = 16;
  localparam logic [3:0] OVS_MID  = 4'(OVS / 2 - 1);
  localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  function automatic logic [31:0] pack_status(input logic ne, input logic full, input logic ovr,
                                              input logic ferr, input logic busy);
    logic [31:0] s;
    s = '0;
    s[ST_NE]   = ne;
    s[ST_FULL] = full;
    s[ST_OVR]  = ovr;
    s[ST_FERR] = ferr;
    s[ST_BUSY] = busy;
    return s;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small receive FIFO; a push into a full FIFO with no pop is dropped and flagged
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             overrun_pulse
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q[AW];
  assign rdata = mem_q[rd_q];
  always_comb begin
    do_pop        = pop & ~empty;
    do_push       = push & (~full | do_pop);
    overrun_pulse = push & full & ~do_pop;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ahbl_uart_rx.sv
// ahbl_uart_rx: AHB-Lite slave UART receiver (16x oversampled 8N1) with a receive FIFO
module ahbl_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] PRESC_RST  = 16'd0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        irq
);
  logic bus_acc, rd, wr, wr_presc, wr_ctrl, pop, push, ferr_set, tick, idle;
  logic dph_valid_q, dph_valid_d, dph_write_q, dph_write_d;
  logic [1:0] dph_addr_q, dph_addr_d;
  logic [15:0] presc_q, presc_d, tick_cnt_q, tick_cnt_d;
  logic en_q, en_d, ie_q, ie_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, brk_q, brk_d;
  state_e state_q, state_d;
  logic [3:0] ovs_q, ovs_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, fifo_rdata;
  logic fifo_empty, fifo_full, ovr_pulse;
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};
  assign HREADYOUT = 1'b1;
  assign bus_acc   = HSEL & HTRANS[1] & HREADY;
  assign rd        = dph_valid_q & ~dph_write_q;
  assign wr        = dph_valid_q & dph_write_q;
  assign wr_presc  = wr & (dph_addr_q == REG_PRESC);
  assign wr_ctrl   = wr & (dph_addr_q == REG_CTRL);
  assign pop       = rd & (dph_addr_q == REG_DATA);
  assign idle      = state_q == S_IDLE;
  assign tick      = en_q & ~idle & (tick_cnt_q == presc_q);
  assign irq       = (~fifo_empty & ie_q) | ovr_q | ferr_q;
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .push         (push),
    .pop          (pop),
    .wdata        (shift_q),
    .rdata        (fifo_rdata),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .overrun_pulse(ovr_pulse)
  );
  always_comb begin
    HRDATA = !rd                      ? 32'h0 :
             dph_addr_q == REG_DATA   ? {24'h0, fifo_empty ? 8'h00 : fifo_rdata} :
             dph_addr_q == REG_STATUS ? pack_status(~fifo_empty, fifo_full, ovr_q, ferr_q, ~idle) :
             dph_addr_q == REG_PRESC  ? {16'h0, presc_q} :
                                        {30'h0, ie_q, en_q};
  end
  always_comb begin
    dph_valid_d = bus_acc;
    dph_write_d = bus_acc ? HWRITE : dph_write_q;
    dph_addr_d  = bus_acc ? HADDR[3:2] : dph_addr_q;
    presc_d     = wr_presc ? HWDATA[15:0] : presc_q;
    en_d        = wr_ctrl ? HWDATA[CT_EN] : en_q;
    ie_d        = wr_ctrl ? HWDATA[CT_IE] : ie_q;
    ovr_d       = ovr_pulse | (ovr_q & ~(wr_ctrl & HWDATA[CT_CLR_OVR]));
    ferr_d      = ferr_set | (ferr_q & ~(wr_ctrl & HWDATA[CT_CLR_FERR]));
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    tick_cnt_d  = (~en_q | idle | tick) ? 16'h0 : tick_cnt_q + 16'd1;
  end
  always_comb begin
    state_d  = state_q;
    ovs_d    = ovs_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    brk_d    = brk_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: if (!rx_s_q) begin
        state_d = S_START;
        ovs_d   = 4'd0;
      end
      S_START: if (tick) begin
        ovs_d = ovs_q + 4'd1;
        if (ovs_q == OVS_MID) begin
          state_d = rx_s_q ? S_IDLE : S_DATA;
          ovs_d   = 4'd0;
          bit_d   = 3'd0;
        end
      end
      S_DATA: if (tick) begin
        ovs_d = ovs_q + 4'd1;
        if (ovs_q == OVS_LAST) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
        end
      end
      S_STOP: if (brk_q) begin
        state_d = rx_s_q ? S_IDLE : S_STOP;
        brk_d   = ~rx_s_q;
      end else if (tick) begin
        ovs_d = ovs_q + 4'd1;
        if (ovs_q == OVS_LAST) begin
          push     = rx_s_q;
          ferr_set = ~rx_s_q;
          brk_d    = ~rx_s_q;
          state_d  = rx_s_q ? S_IDLE : S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // disabling the receiver abandons any frame in progress, including a break wait
    if (!en_q) begin
      state_d = S_IDLE;
      brk_d   = 1'b0;
    end
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      dph_addr_q  <= 2'd0;
      presc_q     <= PRESC_RST;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= 16'h0;
      state_q     <= S_IDLE;
      ovs_q       <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h0;
      brk_q       <= 1'b0;
    end else begin
      dph_valid_q <= dph_valid_d;
      dph_write_q <= dph_write_d;
      dph_addr_q  <= dph_addr_d;
      presc_q     <= presc_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      ovs_q       <= ovs_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
    end
  end
endmodule
